// File: rtl/id_issue_queue.sv
// In-order instruction queue with RV32I head decode, load-use scoreboard and registered issue.
// JAL issue redirects fetch and drops everything queued behind it.
module id_issue_queue #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            flush_in,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_rs1_en,
    output logic            out_rs2_en,
    output logic            out_rd_we,
    output logic [XLEN-1:0] out_imm,
    output logic            out_imm_en,
    output logic [3:0]      out_aluop,
    output logic [3:0]      out_alusel,
    output logic            out_is_load,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            stall_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0]   CntDepth = (PW + 1)'(DEPTH);
    localparam logic [PW:0]   CntOne   = (PW + 1)'(1);
    localparam logic [PW-1:0] PtrOne   = PW'(1);
    localparam logic [2:0]    Lat      = 3'(LOAD_LAT);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;

    localparam logic [3:0] SelNop    = 4'd0;
    localparam logic [3:0] SelLui    = 4'd1;
    localparam logic [3:0] SelAuipc  = 4'd2;
    localparam logic [3:0] SelJal    = 4'd3;
    localparam logic [3:0] SelJalr   = 4'd4;
    localparam logic [3:0] SelBranch = 4'd5;
    localparam logic [3:0] SelLoad   = 4'd6;
    localparam logic [3:0] SelStore  = 4'd7;
    localparam logic [3:0] SelLogic  = 4'd8;

    // Queue storage and pointers
    logic [31:0]     q_inst [DEPTH];
    logic [XLEN-1:0] q_pc   [DEPTH];
    logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [PW:0]     count_q;

    // Scoreboard: cycles until each register's pending load data is usable
    logic [2:0]  sb_q [31:1];
    logic [31:0] busy;

    // Registered issue bundle
    logic            out_valid_q;
    logic [XLEN-1:0] out_pc_q;
    logic [4:0]      out_rs1_q, out_rs2_q, out_rd_q;
    logic            out_rs1_en_q, out_rs2_en_q, out_rd_we_q;
    logic [XLEN-1:0] out_imm_q;
    logic            out_imm_en_q;
    logic [3:0]      out_aluop_q, out_alusel_q;
    logic            out_is_load_q;
    logic            redirect_valid_q;
    logic [XLEN-1:0] redirect_pc_q;

    // Head decode
    logic [31:0]     head_inst;
    logic [XLEN-1:0] head_pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      dec_rs1, dec_rs2, dec_rd;
    logic            dec_rs1_en, dec_rs2_en, dec_rd_wr, dec_rd_we;
    logic            dec_imm_en, dec_is_load;
    logic [3:0]      dec_aluop, dec_alusel;
    logic [31:0]     imm32;
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] jal_target;

    logic empty, hazard, issue, jal_issue, push;

    assign head_inst = q_inst[rd_ptr_q];
    assign head_pc   = q_pc[rd_ptr_q];
    assign opcode    = head_inst[6:0];
    assign funct3    = head_inst[14:12];
    assign dec_rd    = head_inst[11:7];
    assign dec_rs1   = head_inst[19:15];
    assign dec_rs2   = head_inst[24:20];

    always_comb begin
        dec_rs1_en  = 1'b0;
        dec_rs2_en  = 1'b0;
        dec_rd_wr   = 1'b0;
        dec_imm_en  = 1'b0;
        dec_is_load = 1'b0;
        dec_aluop   = 4'd0;
        dec_alusel  = SelNop;
        imm32       = 32'd0;
        unique case (opcode)
            OpLui: begin
                dec_alusel = SelLui;
                dec_rd_wr  = 1'b1;
                dec_imm_en = 1'b1;
                imm32      = {head_inst[31:12], 12'd0};
            end
            OpAuipc: begin
                dec_alusel = SelAuipc;
                dec_rd_wr  = 1'b1;
                dec_imm_en = 1'b1;
                imm32      = {head_inst[31:12], 12'd0};
            end
            OpJal: begin
                dec_alusel = SelJal;
                dec_rd_wr  = 1'b1;
                dec_imm_en = 1'b1;
                imm32      = {{11{head_inst[31]}}, head_inst[31], head_inst[19:12],
                              head_inst[20], head_inst[30:21], 1'b0};
            end
            OpJalr: begin
                dec_alusel = SelJalr;
                dec_rs1_en = 1'b1;
                dec_rd_wr  = 1'b1;
                dec_imm_en = 1'b1;
                dec_aluop  = {1'b0, funct3};
                imm32      = {{20{head_inst[31]}}, head_inst[31:20]};
            end
            OpBranch: begin
                dec_alusel = SelBranch;
                dec_rs1_en = 1'b1;
                dec_rs2_en = 1'b1;
                dec_aluop  = {1'b0, funct3};
                imm32      = {{19{head_inst[31]}}, head_inst[31], head_inst[7],
                              head_inst[30:25], head_inst[11:8], 1'b0};
            end
            OpLoad: begin
                dec_alusel  = SelLoad;
                dec_rs1_en  = 1'b1;
                dec_rd_wr   = 1'b1;
                dec_imm_en  = 1'b1;
                dec_is_load = 1'b1;
                dec_aluop   = {1'b0, funct3};
                imm32       = {{20{head_inst[31]}}, head_inst[31:20]};
            end
            OpStore: begin
                dec_alusel = SelStore;
                dec_rs1_en = 1'b1;
                dec_rs2_en = 1'b1;
                dec_imm_en = 1'b1;
                imm32      = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
            end
            OpImm: begin
                dec_alusel = SelLogic;
                dec_rs1_en = 1'b1;
                dec_rd_wr  = 1'b1;
                dec_imm_en = 1'b1;
                // funct7[5] only distinguishes SRAI from SRLI; elsewhere it is immediate bits
                dec_aluop  = {(funct3 == 3'b101) & head_inst[30], funct3};
                imm32      = {{20{head_inst[31]}}, head_inst[31:20]};
            end
            OpReg: begin
                dec_alusel = SelLogic;
                dec_rs1_en = 1'b1;
                dec_rs2_en = 1'b1;
                dec_rd_wr  = 1'b1;
                dec_aluop  = {head_inst[30], funct3};
            end
            default: ;
        endcase
    end

    assign dec_rd_we  = dec_rd_wr && (dec_rd != 5'd0);
    assign dec_imm    = XLEN'($signed(imm32));
    assign jal_target = head_pc + dec_imm;

    always_comb begin
        busy = 32'd0;
        for (int i = 1; i < 32; i++) begin
            busy[i] = (sb_q[i] != 3'd0);
        end
    end

    // busy[0] is constant 0, so x0 sources never stall
    assign hazard    = (dec_rs1_en && busy[dec_rs1]) || (dec_rs2_en && busy[dec_rs2]);
    assign empty     = (count_q == '0);
    assign stall_o   = !empty && hazard;
    assign in_ready  = (count_q < CntDepth);
    assign issue     = !empty && !hazard && !flush_in && (!out_valid_q || out_ready);
    assign jal_issue = issue && (dec_alusel == SelJal);
    assign push      = in_valid && in_ready && !flush_in && !jal_issue;

    always_ff @(posedge clk_in) begin
        if (push) begin
            q_inst[wr_ptr_q] <= in_inst;
            q_pc[wr_ptr_q]   <= in_pc;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_ptr_q         <= '0;
            wr_ptr_q         <= '0;
            count_q          <= '0;
            out_valid_q      <= 1'b0;
            out_pc_q         <= '0;
            out_rs1_q        <= '0;
            out_rs2_q        <= '0;
            out_rd_q         <= '0;
            out_rs1_en_q     <= 1'b0;
            out_rs2_en_q     <= 1'b0;
            out_rd_we_q      <= 1'b0;
            out_imm_q        <= '0;
            out_imm_en_q     <= 1'b0;
            out_aluop_q      <= '0;
            out_alusel_q     <= '0;
            out_is_load_q    <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else if (flush_in) begin
            rd_ptr_q         <= '0;
            wr_ptr_q         <= '0;
            count_q          <= '0;
            out_valid_q      <= 1'b0;
            redirect_valid_q <= 1'b0;
        end else begin
            if (jal_issue) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
                if (issue) rd_ptr_q <= rd_ptr_q + PtrOne;
                unique case ({push, issue})
                    2'b10:   count_q <= count_q + CntOne;
                    2'b01:   count_q <= count_q - CntOne;
                    default: ;
                endcase
            end

            if (issue) begin
                out_valid_q   <= 1'b1;
                out_pc_q      <= head_pc;
                out_rs1_q     <= dec_rs1;
                out_rs2_q     <= dec_rs2;
                out_rd_q      <= dec_rd;
                out_rs1_en_q  <= dec_rs1_en;
                out_rs2_en_q  <= dec_rs2_en;
                out_rd_we_q   <= dec_rd_we;
                out_imm_q     <= dec_imm;
                out_imm_en_q  <= dec_imm_en;
                out_aluop_q   <= dec_aluop;
                out_alusel_q  <= dec_alusel;
                out_is_load_q <= dec_is_load;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            redirect_valid_q <= jal_issue;
            if (jal_issue) redirect_pc_q <= jal_target;
        end
    end

    // Flush keeps the scoreboard: loads already in EX still complete
    always_ff @(posedge clk_in) begin
        for (int i = 1; i < 32; i++) begin
            if (rst_in) begin
                sb_q[i] <= 3'd0;
            end else if (issue && dec_is_load && (dec_rd == 5'(i))) begin
                sb_q[i] <= Lat;
            end else if (out_ready && (sb_q[i] != 3'd0)) begin
                sb_q[i] <= sb_q[i] - 3'd1;
            end
        end
    end

    assign out_valid      = out_valid_q;
    assign out_pc         = out_pc_q;
    assign out_rs1        = out_rs1_q;
    assign out_rs2        = out_rs2_q;
    assign out_rd         = out_rd_q;
    assign out_rs1_en     = out_rs1_en_q;
    assign out_rs2_en     = out_rs2_en_q;
    assign out_rd_we      = out_rd_we_q;
    assign out_imm        = out_imm_q;
    assign out_imm_en     = out_imm_en_q;
    assign out_aluop      = out_aluop_q;
    assign out_alusel     = out_alusel_q;
    assign out_is_load    = out_is_load_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_id_issue_queue.sv
// Directed bench for id_issue_queue: LOAD_LAT=1 instance plus a LOAD_LAT=3 twin on shared inputs.
module tb_id_issue_queue;

    logic        clk_in = 1'b0;
    logic        rst_in, flush_in, in_valid, out_ready;
    logic [31:0] in_pc, in_inst;

    logic        in_ready, out_valid, out_rs1_en, out_rs2_en, out_rd_we, out_imm_en, out_is_load;
    logic        redirect_valid, stall_o;
    logic [31:0] out_pc, out_imm, redirect_pc;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [3:0]  out_aluop, out_alusel;

    logic        b_in_ready, b_out_valid, b_rs1_en, b_rs2_en, b_rd_we, b_imm_en, b_is_load;
    logic        b_redirect_valid, b_stall;
    logic [31:0] b_out_pc, b_imm, b_redirect_pc;
    logic [4:0]  b_rs1, b_rs2, b_rd;
    logic [3:0]  b_aluop, b_alusel;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    id_issue_queue #(.XLEN(32), .DEPTH(4), .LOAD_LAT(1)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_rs1_en(out_rs1_en), .out_rs2_en(out_rs2_en), .out_rd_we(out_rd_we),
        .out_imm(out_imm), .out_imm_en(out_imm_en), .out_aluop(out_aluop),
        .out_alusel(out_alusel), .out_is_load(out_is_load),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall_o(stall_o)
    );

    id_issue_queue #(.XLEN(32), .DEPTH(4), .LOAD_LAT(3)) dut3 (
        .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc),
        .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd),
        .out_rs1_en(b_rs1_en), .out_rs2_en(b_rs2_en), .out_rd_we(b_rd_we),
        .out_imm(b_imm), .out_imm_en(b_imm_en), .out_aluop(b_aluop),
        .out_alusel(b_alusel), .out_is_load(b_is_load),
        .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc), .stall_o(b_stall)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in    = 1'b1;
        flush_in  = 1'b0;
        in_valid  = 1'b0;
        in_pc     = 32'd0;
        in_inst   = 32'd0;
        out_ready = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] inst);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = inst;
        tick();
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] addi_k(input int k);
        logic [11:0] imm;
        logic [4:0]  rd;
        imm = 12'(k);
        rd  = 5'(k + 1);
        return {imm, 5'd0, 3'd0, rd, 7'h13};
    endfunction

    initial begin
        int s1, s3, v1, v3, n;
        logic [31:0] got [8];

        // Reset state
        do_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_redirect_valid", redirect_valid, 0);
        check("rst_redirect_pc", redirect_pc, 0);
        check("rst_stall", stall_o, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_pc", out_pc, 0);
        check("rst_alusel", out_alusel, 0);

        // ADDI x1,x0,5: valid one edge after the push
        push(32'h0, 32'h00500093);
        check("addi_latency", out_valid, 0);
        tick();
        check("addi_valid", out_valid, 1);
        check("addi_rd", out_rd, 1);
        check("addi_imm", out_imm, 5);
        check("addi_alusel", out_alusel, 8);
        check("addi_aluop", out_aluop, 0);
        check("addi_rd_we", out_rd_we, 1);
        check("addi_imm_en", out_imm_en, 1);
        check("addi_rs1_en", out_rs1_en, 1);

        // LW x2,0(x1) then ADD x3,x2,x2: bubbles equal LOAD_LAT
        do_reset();
        push(32'h10, 32'h0000A103);
        push(32'h14, 32'h002101B3);
        check("lw_is_load", out_is_load, 1);
        check("lw_alusel", out_alusel, 6);
        s1 = 0; s3 = 0; v1 = 0; v3 = 0;
        for (int i = 0; i < 10; i++) begin
            s1 += int'(stall_o);
            s3 += int'(b_stall);
            if (out_valid && out_rd == 5'd3) v1++;
            if (b_out_valid && b_rd == 5'd3) v3++;
            tick();
        end
        check("lat1_stall_cycles", s1, 1);
        check("lat3_stall_cycles", s3, 3);
        check("lat1_add_issued", v1, 1);
        check("lat3_add_issued", v3, 1);

        // Load to x0 never creates a hazard
        do_reset();
        push(32'h20, 32'h0000A003);
        push(32'h24, 32'h000001B3);
        check("lw_x0_rd_we", out_rd_we, 0);
        s1 = 0; s3 = 0; v1 = 0; v3 = 0;
        for (int i = 0; i < 10; i++) begin
            s1 += int'(stall_o);
            s3 += int'(b_stall);
            if (out_valid && out_rd == 5'd3) v1++;
            if (b_out_valid && b_rd == 5'd3) v3++;
            tick();
        end
        check("x0_lat1_stall", s1, 0);
        check("x0_lat3_stall", s3, 0);
        check("x0_lat1_issued", v1, 1);
        check("x0_lat3_issued", v3, 1);

        // JAL with two queued behind it and a push on the issue edge
        do_reset();
        out_ready = 1'b0;
        push(32'h0f0, 32'h00500093);
        push(32'h100, 32'h010000EF);
        push(32'h104, addi_k(1));
        push(32'h108, addi_k(2));
        out_ready = 1'b1;
        push(32'h300, addi_k(3));
        check("jal_valid", out_valid, 1);
        check("jal_alusel", out_alusel, 3);
        check("jal_pc", out_pc, 32'h100);
        check("jal_redirect_valid", redirect_valid, 1);
        check("jal_redirect_pc", redirect_pc, 32'h110);
        check("jal_in_ready", in_ready, 1);
        tick();
        check("jal_redirect_drop", redirect_valid, 0);
        v1 = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid) v1++;
            tick();
        end
        check("jal_discarded", v1, 0);

        // Fill with out_ready low: 5 of 6 accepted, then drain in order
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) push(32'h200 + 32'(4 * k), addi_k(k));
        check("full_in_ready", in_ready, 0);
        check("full_out_valid", out_valid, 1);
        check("full_out_pc", out_pc, 32'h200);
        out_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) begin
                if (n < 8) got[n] = out_pc;
                n++;
            end
            tick();
        end
        check("drain_count", n, 5);
        for (int k = 0; k < 5; k++) check($sformatf("drain_pc%0d", k), got[k], 32'h200 + 32'(4 * k));

        // Flush while full keeps the pending load in the scoreboard
        do_reset();
        out_ready = 1'b0;
        push(32'h400, 32'h0000A103);
        for (int k = 0; k < 4; k++) push(32'h404 + 32'(4 * k), 32'h00500093);
        check("pre_flush_in_ready", in_ready, 0);
        check("pre_flush_valid", out_valid, 1);
        check("pre_flush_is_load", out_is_load, 1);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        check("flush_redirect", redirect_valid, 0);
        push(32'h500, 32'h002101B3);
        check("flush_reader_stall", stall_o, 1);
        out_ready = 1'b1;
        tick();
        check("flush_stall_clear", stall_o, 0);
        tick();
        check("flush_reader_valid", out_valid, 1);
        check("flush_reader_rd", out_rd, 3);

        // SRAI, SUB, SW decode
        do_reset();
        push(32'h600, 32'h40335293);
        in_valid = 1'b1;
        in_pc    = 32'h604;
        in_inst  = 32'h406283B3;
        tick();
        check("srai_aluop", out_aluop, 4'b1101);
        check("srai_imm_en", out_imm_en, 1);
        check("srai_rs1", out_rs1, 6);
        check("srai_rd", out_rd, 5);
        in_pc   = 32'h608;
        in_inst = 32'hFE62AE23;
        tick();
        in_valid = 1'b0;
        check("sub_aluop", out_aluop, 4'b1000);
        check("sub_imm_en", out_imm_en, 0);
        check("sub_rs2_en", out_rs2_en, 1);
        tick();
        check("sw_alusel", out_alusel, 7);
        check("sw_aluop", out_aluop, 0);
        check("sw_imm", out_imm, 32'hFFFFFFFC);
        check("sw_rd_we", out_rd_we, 0);
        check("sw_imm_en", out_imm_en, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
